// File: rtl/mem_arbiter.sv
// Two-port (I-cache / D-cache) to single-memory arbiter with round-robin grant,
// registered outputs and a per-access BUSY timeout that returns ERR_DATA.
module mem_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ic_req_addr,
  input  logic        ic_req_valid,
  input  logic        ic_req_wr,
  input  logic [31:0] ic_wr_data,
  output logic [31:0] ic_rsp_data,
  output logic        ic_rsp_ready,
  input  logic [31:0] dc_req_addr,
  input  logic        dc_req_valid,
  input  logic        dc_req_wr,
  input  logic [31:0] dc_wr_data,
  output logic [31:0] dc_rsp_data,
  output logic        dc_rsp_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_req_valid,
  output logic        mem_req_wr,
  input  logic [31:0] mem_req_data,
  input  logic        mem_req_ready,
  output logic        mem_err,
  output logic        grant_id
);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  // Abort fires at the end of the TIMEOUT-th BUSY cycle without ready.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] mem_req_addr_q, mem_req_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic        mem_req_valid_q, mem_req_valid_d;
  logic        mem_req_wr_q, mem_req_wr_d;
  logic [31:0] ic_rsp_data_q, ic_rsp_data_d;
  logic [31:0] dc_rsp_data_q, dc_rsp_data_d;
  logic        ic_rsp_ready_q, ic_rsp_ready_d;
  logic        dc_rsp_ready_q, dc_rsp_ready_d;
  logic        mem_err_q, mem_err_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        winner;

  // On a tie the requester that did not win last time takes the grant.
  assign winner = (ic_req_valid && dc_req_valid) ? ~last_grant_q : dc_req_valid;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_wr_data_d   = mem_wr_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_wr_d    = mem_req_wr_q;
    ic_rsp_data_d   = ic_rsp_data_q;
    dc_rsp_data_d   = dc_rsp_data_q;
    ic_rsp_ready_d  = 1'b0;
    dc_rsp_ready_d  = 1'b0;
    mem_err_d       = mem_err_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (ic_req_valid || dc_req_valid) begin
          grant_d         = winner;
          last_grant_d    = winner;
          mem_req_addr_d  = winner ? dc_req_addr : ic_req_addr;
          mem_wr_data_d   = winner ? dc_wr_data : ic_wr_data;
          mem_req_wr_d    = winner ? dc_req_wr : ic_req_wr;
          mem_req_valid_d = 1'b1;
          cnt_d           = '0;
          state_d         = StBusy;
        end
      end
      StBusy: begin
        if (mem_req_ready || cnt_q == TimeoutLast) begin
          mem_req_valid_d = 1'b0;
          state_d         = StResp;
          if (grant_q) begin
            dc_rsp_data_d  = mem_req_ready ? mem_req_data : ERR_DATA;
            dc_rsp_ready_d = 1'b1;
          end else begin
            ic_rsp_data_d  = mem_req_ready ? mem_req_data : ERR_DATA;
            ic_rsp_ready_d = 1'b1;
          end
          if (!mem_req_ready) mem_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      mem_req_addr_q  <= '0;
      mem_wr_data_q   <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_wr_q    <= 1'b0;
      ic_rsp_data_q   <= '0;
      dc_rsp_data_q   <= '0;
      ic_rsp_ready_q  <= 1'b0;
      dc_rsp_ready_q  <= 1'b0;
      mem_err_q       <= 1'b0;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_wr_data_q   <= mem_wr_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_wr_q    <= mem_req_wr_d;
      ic_rsp_data_q   <= ic_rsp_data_d;
      dc_rsp_data_q   <= dc_rsp_data_d;
      ic_rsp_ready_q  <= ic_rsp_ready_d;
      dc_rsp_ready_q  <= dc_rsp_ready_d;
      mem_err_q       <= mem_err_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
    end
  end

  assign mem_req_addr  = mem_req_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_wr    = mem_req_wr_q;
  assign ic_rsp_data   = ic_rsp_data_q;
  assign dc_rsp_data   = dc_rsp_data_q;
  assign ic_rsp_ready  = ic_rsp_ready_q;
  assign dc_rsp_ready  = dc_rsp_ready_q;
  assign mem_err       = mem_err_q;
  assign grant_id      = grant_q;

endmodule
